// File: rtl/snn_decay_pkg.sv
// Shared definitions for the membrane-potential decay datapath.
// Contents: decay-rate codes, FP32 field positions, and the sweep FSM state type.
package snn_decay_pkg;

  // Decay-rate codes. Each neuron stores one of these codes. Any other code means divide by 1.
  localparam logic [3:0] RATE_DIV1   = 4'b0001;
  localparam logic [3:0] RATE_DIV2   = 4'b0010;
  localparam logic [3:0] RATE_DIV4   = 4'b0100;
  localparam logic [3:0] RATE_DIV8   = 4'b1000;
  localparam logic [3:0] RATE_MUL075 = 4'b0011;

  // IEEE-754 single-precision field positions.
  localparam int unsigned FP_SIGN_BIT = 31;
  localparam int unsigned FP_EXP_MSB  = 30;
  localparam int unsigned FP_EXP_LSB  = 23;
  localparam int unsigned FP_MAN_MSB  = 22;
  localparam logic [7:0]  EXP_INF     = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    EMIT,
    FIN
  } decay_state_e;

endpackage

// File: rtl/fp32_exp_decay.sv
// Combinational LIF decay of one FP32 value using exponent arithmetic only.
// Ports:
//   x    - input potential (FP32)
//   rate - 4-bit decay-rate code
//   y    - decayed potential (FP32). Denormal results flush to zero. Inf/NaN pass through.
module fp32_exp_decay
  import snn_decay_pkg::*;
(
  input  logic [31:0] x,
  input  logic [3:0]  rate,
  output logic [31:0] y
);

  logic        sgn;
  logic [7:0]  exp_in;
  logic [22:0] man;
  logic [23:0] sig;
  logic [24:0] sum;
  logic [7:0]  shift_k;

  assign sgn    = x[FP_SIGN_BIT];
  assign exp_in = x[FP_EXP_MSB:FP_EXP_LSB];
  assign man    = x[FP_MAN_MSB:0];
  assign sig    = {1'b1, man};
  // Compute 1.5 * sig with the LSB truncated. The result exponent is then e-1, so the value is 0.75x.
  assign sum    = {1'b0, sig} + ({1'b0, sig} >> 1);

  always_comb begin
    shift_k = 8'd0;
    case (rate)
      RATE_DIV2: shift_k = 8'd1;
      RATE_DIV4: shift_k = 8'd2;
      RATE_DIV8: shift_k = 8'd3;
      default:   shift_k = 8'd0;
    endcase
  end

  always_comb begin
    y = x;
    if (exp_in == 8'd0) begin
      y = {sgn, 31'b0};
    end else if (exp_in == EXP_INF) begin
      y = x;
    end else if (rate == RATE_MUL075) begin
      if (exp_in <= 8'd1) begin
        y = {sgn, 31'b0};
      end else if (sum[24]) begin
        // Normalise the carry back into range. The exponent decrement cancels, so the exponent stays e.
        y = {sgn, exp_in, sum[23:1]};
      end else begin
        y = {sgn, exp_in - 8'd1, sum[22:0]};
      end
    end else if (shift_k != 8'd0) begin
      if (exp_in <= shift_k) begin
        y = {sgn, 31'b0};
      end else begin
        y = {sgn, exp_in - shift_k, man};
      end
    end
  end

endmodule

// File: rtl/potential_decay_bank.sv
// Bank of NUM_NEURONS FP32 membrane potentials with a per-neuron decay rate.
// A timestep_start pulse starts a sweep. The sweep decays each neuron in turn, streams the result out
// on a valid/ready port and writes the result back into the bank.
// Ports:
//   CLK, RST_N                  - clock, asynchronous active-low reset
//   init_*                      - load a potential and a rate code (has priority over acc_*)
//   acc_*                       - load a potential from the adder
//   wr_ready                    - writes are accepted (not busy)
//   timestep_start              - starts a sweep (ignored while busy)
//   busy                        - a sweep is in progress
//   out_valid/out_ready         - output handshake
//   out_addr, out_potential     - neuron index and decayed value
//   done                        - one-cycle pulse at the end of a sweep
module potential_decay_bank
  import snn_decay_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned ADDR_W      = 4,
  parameter logic [3:0]  RESET_RATE  = 4'b0001
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              init_valid,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [31:0]       init_potential,
  input  logic [3:0]        init_rate,
  input  logic              acc_valid,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [31:0]       acc_potential,
  output logic              wr_ready,
  input  logic              timestep_start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_potential,
  output logic              done
);

  localparam logic [ADDR_W:0]   NumNeurons = (ADDR_W + 1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LastIdx    = ADDR_W'(NUM_NEURONS - 1);

  decay_state_e      state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       bank_q [NUM_NEURONS];
  logic [31:0]       bank_d [NUM_NEURONS];
  logic [3:0]        rate_q [NUM_NEURONS];
  logic [3:0]        rate_d [NUM_NEURONS];
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [31:0]       out_pot_q, out_pot_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       decay_y;
  logic              init_in_range, acc_in_range;

  fp32_exp_decay u_decay (
    .x    (bank_q[idx_q]),
    .rate (rate_q[idx_q]),
    .y    (decay_y)
  );

  assign init_in_range = ({1'b0, init_addr} < NumNeurons);
  assign acc_in_range  = ({1'b0, acc_addr} < NumNeurons);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bank_d      = bank_q;
    rate_d      = rate_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_pot_d   = out_pot_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The init strobe takes priority even when its address is out of range.
        if (init_valid) begin
          if (init_in_range) begin
            bank_d[init_addr] = init_potential;
            rate_d[init_addr] = init_rate;
          end
        end else if (acc_valid && acc_in_range) begin
          bank_d[acc_addr] = acc_potential;
        end
        if (timestep_start) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        out_pot_d   = decay_y;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
        state_d     = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          bank_d[idx_q] = out_pot_q;
          out_valid_d   = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = CALC;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_pot_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        bank_q[i] <= '0;
        rate_q[i] <= RESET_RATE;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_pot_q   <= out_pot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bank_q      <= bank_d;
      rate_q      <= rate_d;
    end
  end

  assign wr_ready      = ~busy_q;
  assign busy          = busy_q;
  assign out_valid     = out_valid_q;
  assign out_addr      = out_addr_q;
  assign out_potential = out_pot_q;
  assign done          = done_q;

endmodule

// File: tb/tb_potential_decay_bank.sv
// Scoreboard bench for potential_decay_bank. Each sweep queues the expected outputs from a
// reference model. A separate monitor compares every accepted output against that queue.
module tb_potential_decay_bank;

  localparam int NN = 10;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          init_valid, acc_valid, timestep_start, out_ready;
  logic [AW-1:0] init_addr, acc_addr;
  logic [31:0]   init_potential, acc_potential;
  logic [3:0]    init_rate;
  logic          wr_ready, busy, out_valid, done;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_potential;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   pot;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_bank [NN];
  logic [3:0]  m_rate [NN];

  potential_decay_bank #(
    .NUM_NEURONS (NN),
    .ADDR_W      (AW),
    .RESET_RATE  (4'b0001)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .init_valid     (init_valid),
    .init_addr      (init_addr),
    .init_potential (init_potential),
    .init_rate      (init_rate),
    .acc_valid      (acc_valid),
    .acc_addr       (acc_addr),
    .acc_potential  (acc_potential),
    .wr_ready       (wr_ready),
    .timestep_start (timestep_start),
    .busy           (busy),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_addr       (out_addr),
    .out_potential  (out_potential),
    .done           (done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Reference model. It scales the value by the rate and then flushes any subnormal result to zero.
  function automatic logic [31:0] ref_decay(input logic [31:0] x, input logic [3:0] r);
    int      e;
    int      k;
    int      ne;
    longint  prod;
    logic [31:0] zero;
    logic [7:0]  ne8;
    logic [22:0] m23;
    e    = int'(x[30:23]);
    zero = {x[31], 31'b0};
    if (e == 0) return zero;
    if (e == 255) return x;
    case (r)
      4'b0010: k = 1;
      4'b0100: k = 2;
      4'b1000: k = 3;
      4'b0011: begin
        if (e <= 1) return zero;
        prod = ((longint'(1) << 23) + longint'(x[22:0])) * 3 / 2;
        ne   = e - 1;
        while (prod >= (longint'(1) << 24)) begin
          prod = prod / 2;
          ne++;
        end
        ne8 = 8'(ne);
        m23 = 23'(prod);
        return {x[31], ne8, m23};
      end
      default: return x;
    endcase
    if (e <= k) return zero;
    ne8 = 8'(e - k);
    return {x[31], ne8, x[22:0]};
  endfunction

  // Monitor: pops the queue on every handshake and checks that held outputs stay stable.
  initial begin : monitor
    exp_t        e;
    bit          prev_hold = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0] prev_pot = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev_hold = 0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_addr", 32'(out_addr), 32'(prev_addr));
          chk("hold_pot", out_potential, prev_pot);
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", 32'(out_addr), 32'hFFFFFFFF);
          end else begin
            e = sb_q.pop_front();
            chk("out_addr", 32'(out_addr), 32'(e.addr));
            chk("out_potential", out_potential, e.pot);
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_addr = out_addr;
        prev_pot  = out_potential;
      end
    end
  end

  task automatic do_write(input bit iv, input logic [AW-1:0] ia, input logic [31:0] ip,
                          input logic [3:0] ir, input bit av, input logic [AW-1:0] aa,
                          input logic [31:0] ap);
    init_valid = iv; init_addr = ia; init_potential = ip; init_rate = ir;
    acc_valid = av; acc_addr = aa; acc_potential = ap;
    @(posedge CLK); #1;
    init_valid = 0; acc_valid = 0;
    if (iv) begin
      if (int'(ia) < NN) begin m_bank[ia] = ip; m_rate[ia] = ir; end
    end else if (av && int'(aa) < NN) begin
      m_bank[aa] = ap;
    end
  endtask

  task automatic run_sweep(input int stall_len, input bit try_acc);
    int cyc;
    int stalls;
    logic [31:0] e;
    for (int i = 0; i < NN; i++) begin
      e = ref_decay(m_bank[i], m_rate[i]);
      sb_q.push_back({AW'(i), e});
      m_bank[i] = e;
    end
    @(posedge CLK); #1;
    timestep_start = 1;
    @(posedge CLK); #1;
    timestep_start = 0;
    cyc = 0;
    stalls = stall_len;
    forever begin
      out_ready = 1;
      if (stalls > 0 && out_valid && out_addr == AW'(3)) begin
        out_ready = 0;
        stalls--;
      end
      if (try_acc && cyc == 3) begin
        acc_valid = 1; acc_addr = '0; acc_potential = 32'hDEADBEEF;
        chk("wr_ready_busy", 32'(wr_ready), 32'd0);
      end else begin
        acc_valid = 0;
      end
      @(negedge CLK);
      if (done) break;
      if (cyc >= 300) begin
        chk("sweep_timeout", 32'(cyc), 32'(2 * NN + 1 + stall_len));
        break;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    acc_valid = 0;
    out_ready = 1;
    chk("sweep_len", 32'(cyc), 32'(2 * NN + 1 + stall_len));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    @(posedge CLK); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] ex;
    case ($urandom_range(0, 7))
      0: ex = 8'd0;
      1: ex = 8'd1;
      2: ex = 8'd2;
      3: ex = 8'd3;
      4: ex = 8'd255;
      default: ex = 8'($urandom_range(4, 254));
    endcase
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  function automatic logic [3:0] rand_rate();
    case ($urandom_range(0, 5))
      0: return 4'b0001;
      1: return 4'b0010;
      2: return 4'b0100;
      3: return 4'b1000;
      4: return 4'b0011;
      default: return 4'($urandom);
    endcase
  endfunction

  logic [31:0] dir_val  [NN] = '{32'h41000000, 32'h41000000, 32'h41000000, 32'h3FC00000,
                                 32'h41000000, 32'h00800000, 32'h80400000, 32'h7F800000,
                                 32'hC1000000, 32'h7FC00001};
  logic [3:0]  dir_rate [NN] = '{4'b0100, 4'b1000, 4'b0011, 4'b0011, 4'b0111, 4'b0010,
                                 4'b0001, 4'b0010, 4'b0010, 4'b0011};

  initial begin : stim
    int wait_n;
    RST_N = 0; init_valid = 0; acc_valid = 0; timestep_start = 0; out_ready = 1;
    init_addr = '0; acc_addr = '0; init_potential = '0; acc_potential = '0; init_rate = '0;
    for (int i = 0; i < NN; i++) begin m_bank[i] = '0; m_rate[i] = 4'b0001; end
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_pot", out_potential, 32'd0);
    RST_N = 1;
    @(posedge CLK); #1;
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);

    // Basic sweep, then a second sweep that reads back the written-back values.
    for (int i = 0; i < NN; i++)
      do_write(1, AW'(i), (i == 7) ? 32'h4212147B : 32'h40800000,
               (i == 7) ? 4'b0010 : 4'b0001, 0, '0, '0);
    run_sweep(0, 0);
    run_sweep(0, 0);

    // Directed rate and special-value vectors, with backpressure on neuron 3.
    for (int i = 0; i < NN; i++) do_write(1, AW'(i), dir_val[i], dir_rate[i], 0, '0, '0);
    run_sweep(5, 0);

    // An acc write while busy is dropped. The next sweep sees the bank unchanged.
    run_sweep(0, 1);
    run_sweep(0, 0);

    // Init priority over acc on the same address, and out-of-range addresses are ignored.
    do_write(1, AW'(2), 32'h42C80000, 4'b0010, 1, AW'(2), 32'h3F800000);
    do_write(0, '0, '0, '0, 1, AW'(12), 32'h12345678);
    do_write(1, AW'(12), 32'h12345678, 4'b0100, 0, '0, '0);
    do_write(0, '0, '0, '0, 1, AW'(5), 32'h44000000);
    run_sweep(0, 0);

    // Randomised sweeps.
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 12; w++) begin
        if ($urandom_range(0, 1) == 1)
          do_write(1, AW'($urandom_range(0, 13)), rand_fp(), rand_rate(),
                   1'($urandom_range(0, 1)), AW'($urandom_range(0, 13)), rand_fp());
        else
          do_write(0, '0, '0, '0, 1, AW'($urandom_range(0, 13)), rand_fp());
      end
      run_sweep((s == 2) ? 3 : 0, 0);
    end

    // Assert reset while neuron 4 is being output. The sweep aborts and the bank clears.
    for (int i = 0; i < NN; i++) do_write(1, AW'(i), rand_fp(), rand_rate(), 0, '0, '0);
    for (int i = 0; i < NN; i++) sb_q.push_back({AW'(i), ref_decay(m_bank[i], m_rate[i])});
    @(posedge CLK); #1;
    timestep_start = 1;
    @(posedge CLK); #1;
    timestep_start = 0;
    wait_n = 0;
    while (!(out_valid && out_addr == AW'(4)) && wait_n < 100) begin
      @(posedge CLK); #1;
      wait_n++;
    end
    chk("reach_neuron4", 32'(out_addr), 32'd4);
    out_ready = 0;
    RST_N = 0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    sb_q.delete();
    for (int i = 0; i < NN; i++) begin m_bank[i] = '0; m_rate[i] = 4'b0001; end
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1;
    out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk("no_done_after_abort", 32'(done), 32'd0);
    end
    chk("arst_wr_ready", 32'(wr_ready), 32'd1);
    run_sweep(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/potential_decay_bank.md
Name: potential_decay_bank

Overview:
- Parametrised successor to the single-neuron decay block; holds membrane potentials for NUM_NEURONS neurons in an internal register bank.
- Each potential is IEEE-754 single precision. Each neuron has its own 4-bit decay-rate code.
- On each timestep_start pulse the block sweeps all neurons and applies LIF decay by exponent arithmetic. Each decayed value is streamed out on a valid/ready port and written back to the bank.
- Sits between the potential adder (acc_* writes) and the spike/threshold stage (out_* stream).

Parameters:
NUM_NEURONS, 10, number of neurons in the bank (2..256)
ADDR_W, 4, neuron address width; must satisfy 2**ADDR_W >= NUM_NEURONS
RESET_RATE, 4'b0001, decay-rate code loaded into every neuron at reset

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
init_valid  in  1  load initial potential and rate for one neuron
init_addr  in  ADDR_W  neuron to initialise
init_potential  in  32  initial potential (FP32)
init_rate  in  4  decay-rate code
acc_valid  in  1  potential-adder write strobe
acc_addr  in  ADDR_W  neuron being written
acc_potential  in  32  accumulated potential (FP32)
wr_ready  out  1  high when init/acc writes are accepted (= ~busy)
timestep_start  in  1  one-cycle pulse that begins a decay sweep
busy  out  1  sweep in progress
out_valid  out  1  decayed value available
out_ready  in  1  downstream accepts the value
out_addr  out  ADDR_W  neuron index of the output
out_potential  out  32  decayed potential (FP32)
done  out  1  one-cycle pulse after the last neuron is accepted

Behaviour:
- Reset, asynchronous while RST_N=0:
  - All bank potentials = 32'h0; all rates = RESET_RATE.
  - FSM = IDLE; index = 0.
  - busy=0, out_valid=0, done=0, out_addr=0, out_potential=0. wr_ready=1 after reset.
  - Reset mid-sweep aborts the sweep; no done pulse is produced.
- Writes (IDLE only):
  - If init_valid, the bank entry and rate at init_addr are written.
  - Else if acc_valid, only the potential at acc_addr is written.
  - init has priority when both are high.
  - Addresses >= NUM_NEURONS are ignored.
  - Writes while busy=1 are dropped; wr_ready=0 tells the source.
- FSM:
  - IDLE: when timestep_start=1, index <= 0 and go to CALC; busy <= 1. A timestep_start while busy is ignored.
  - CALC (1 cycle): read bank[index], compute the decay, register out_potential and out_addr=index, set out_valid=1, go to EMIT.
  - EMIT: hold all outputs stable while out_ready=0.
    - On out_valid && out_ready, write out_potential back to bank[index] and drop out_valid.
    - If index == NUM_NEURONS-1, go to FIN; else index+1 and go to CALC.
  - FIN: done=1 for 1 cycle, busy=0, go to IDLE.
- Timing:
  - Throughput: 2 cycles per neuron with out_ready held high.
  - Sweep length: 2*NUM_NEURONS+1 cycles from the timestep_start edge to the done pulse.
- Decay arithmetic. Fields: s = x[31], e = x[30:23], m = x[22:0].
  - Rate 0001: /1, pass-through.
  - Rate 0010 / 0100 / 1000: /2, /4, /8, i.e. e-k with k = 1, 2, 3.
  - Rate 0011: x*0.75, computed as x/2 + x/4.
    - sig = {1,m} (24 bit); sum = sig + (sig>>1), 25 bit, LSB truncated.
    - Result exponent = e-1.
    - If sum[24]=1, shift sum right 1 (truncate) and use exponent e; mantissa = sum[22:0] after normalisation.
  - Any other code: /1.
  - Special cases:
    - e == 0 (zero or denormal): output {s, 31'b0}.
    - e == 255 (Inf or NaN): pass through unchanged.
    - Underflow, where e <= k for the shift rates or e <= 1 for 0011: output {s, 31'b0}. Flush to zero, no denormals.
  - Combinational, one cycle; no multiplier or general adder required.

Decomposition:
- Shared package snn_decay_pkg with:
  - Localparams for the rate codes: RATE_DIV1, RATE_DIV2, RATE_DIV4, RATE_DIV8, RATE_MUL075.
  - FP32 field positions and EXP_INF=8'hFF.
  - FSM state enum: IDLE, CALC, EMIT, FIN.
- One sub-module, fp32_exp_decay: purely combinational, inputs x[31:0] and rate[3:0], output y[31:0]. It implements the arithmetic rules above and is unit-testable on its own.

Test Plan:
- Reset then single sweep, NUM_NEURONS=10, out_ready=1:
  - init neuron 7 = 32'h4212147B (36.52), rate 0010; others 32'h40800000 (4.0), rate 0001.
  - Pulse timestep_start.
  - Expect neuron 7 output 32'h4192147B; others 32'h40800000.
  - done high exactly at cycle 21 after the pulse; bank[7] reads back 32'h4192147B on the next sweep.
- Rate coverage on 32'h41000000 (8.0):
  - 0100 -> 32'h40000000; 1000 -> 32'h3F800000.
  - 0011 -> 32'h40C00000 (6.0); 0011 on 32'h3FC00000 (1.5) -> 32'h3F900000 (1.125).
  - Code 0111 -> 32'h41000000.
- Specials:
  - 32'h00800000 with rate 0010 -> 32'h00000000.
  - 32'h80400000 (denormal) -> 32'h80000000.
  - 32'h7F800000 -> unchanged; 32'hC1000000, rate 0010 -> 32'hC0800000.
- Backpressure: hold out_ready=0 for 5 cycles on neuron 3.
  - out_valid, out_addr=3 and out_potential stay stable.
  - No index advance; total sweep length grows by 5 cycles.
- Write blocking and priority:
  - acc_valid during busy: dropped, wr_ready=0, bank unchanged.
  - In IDLE, init_valid and acc_valid both high on the same addr: init value stored.
  - acc_addr=12 is ignored.
- Async reset mid-sweep:
  - Assert RST_N=0 while in EMIT for neuron 4: out_valid, busy and done all drop immediately; no done pulse.
  - After release, all bank entries read as 0 on the next sweep.
